frame_draw_scheduler: RTL and testbench

//  Per-frame sequencer for the sprite draw path. On each frame tick it runs one

---
 rtl/frame_draw_scheduler.sv | 153 +++++++++++++++
 tb/tb_frame_draw_scheduler.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_draw_scheduler.sv
// Per-frame sprite draw sequencer: one framebuffer clear, then every active
// ship, asteroid and shot slot is handed to the sprite drawer in fixed order.
module frame_draw_scheduler #(
  parameter int MAX_SHIPS     = 1,
  parameter int MAX_ASTEROIDS = 5,
  parameter int MAX_SHOTS     = 10,
  parameter int IDX_W         = 4,
  parameter int ACTIVE_BIT    = 29,
  parameter int TIMEOUT       = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             frame_tick,
  output logic [2:0]       sel_type,
  output logic [IDX_W-1:0] sel_index,
  input  logic [29:0]      ent_word,
  output logic             clear_start,
  input  logic             clear_done,
  output logic             draw_start,
  output logic [29:0]      draw_entity,
  output logic [2:0]       draw_type,
  input  logic             draw_done,
  output logic             busy,
  output logic             frame_done,
  output logic             overrun,
  output logic             timeout_err
);

  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [2:0] T_NONE = 3'b000;
  localparam logic [2:0] T_SHIP = 3'b100;
  localparam logic [2:0] T_AST  = 3'b010;
  localparam logic [2:0] T_SHOT = 3'b001;

  typedef enum logic [2:0] {
    IDLE, CLR_REQ, CLR_WAIT, FETCH, DRW_REQ, DRW_WAIT, NEXT, DONE
  } state_t;

  state_t            state, state_nxt;
  logic [2:0]        grp, grp_nxt;
  logic [IDX_W-1:0]  idx, idx_nxt;
  logic [WD_W-1:0]   wd_cnt;
  logic              wd_expire;
  logic              in_wait;

  // Next non-empty group after g; T_NONE as input asks for the first one.
  function automatic logic [2:0] grp_after(input logic [2:0] g);
    logic [2:0] r;
    r = T_NONE;
    if (g == T_NONE && MAX_SHIPS > 0)
      r = T_SHIP;
    else if ((g == T_NONE || g == T_SHIP) && MAX_ASTEROIDS > 0)
      r = T_AST;
    else if (g != T_SHOT && MAX_SHOTS > 0)
      r = T_SHOT;
    return r;
  endfunction

  function automatic logic [IDX_W:0] grp_size(input logic [2:0] g);
    logic [IDX_W:0] n;
    case (g)
      T_SHIP:  n = (IDX_W+1)'(MAX_SHIPS);
      T_AST:   n = (IDX_W+1)'(MAX_ASTEROIDS);
      T_SHOT:  n = (IDX_W+1)'(MAX_SHOTS);
      default: n = '0;
    endcase
    return n;
  endfunction

  assign in_wait   = (state == CLR_WAIT) || (state == DRW_WAIT);
  assign wd_expire = (wd_cnt == WD_W'(TIMEOUT - 1));

  always_comb begin
    state_nxt   = state;
    grp_nxt     = grp;
    idx_nxt     = idx;
    timeout_err = 1'b0;
    case (state)
      IDLE:     if (frame_tick && enable) state_nxt = CLR_REQ;
      CLR_REQ:  state_nxt = CLR_WAIT;
      CLR_WAIT: begin
        if (clear_done || wd_expire) begin
          timeout_err = !clear_done;
          grp_nxt     = grp_after(T_NONE);
          idx_nxt     = '0;
          state_nxt   = (grp_after(T_NONE) == T_NONE) ? DONE : FETCH;
        end
      end
      FETCH:    state_nxt = ent_word[ACTIVE_BIT] ? DRW_REQ : NEXT;
      DRW_REQ:  state_nxt = DRW_WAIT;
      DRW_WAIT: begin
        if (draw_done || wd_expire) begin
          timeout_err = !draw_done;
          state_nxt   = NEXT;
        end
      end
      NEXT: begin
        if (({1'b0, idx} + (IDX_W+1)'(1)) >= grp_size(grp)) begin
          grp_nxt   = grp_after(grp);
          idx_nxt   = '0;
          state_nxt = (grp_after(grp) == T_NONE) ? DONE : FETCH;
        end else begin
          idx_nxt   = idx + 1'b1;
          state_nxt = FETCH;
        end
      end
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      grp   <= T_NONE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      grp   <= grp_nxt;
      idx   <= idx_nxt;
    end
  end

  // Watchdog: zero outside the wait states, so every wait starts from 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        wd_cnt <= '0;
    else if (in_wait) wd_cnt <= wd_cnt + 1'b1;
    else              wd_cnt <= '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      draw_entity <= '0;
      draw_type   <= T_NONE;
      overrun     <= 1'b0;
    end else begin
      overrun <= frame_tick && (state != IDLE);
      if (state == FETCH && ent_word[ACTIVE_BIT]) begin
        draw_entity <= ent_word;
        draw_type   <= grp;
      end
    end
  end

  assign sel_type    = (state == FETCH || state == NEXT) ? grp : T_NONE;
  assign sel_index   = idx;
  assign clear_start = (state == CLR_REQ);
  assign draw_start  = (state == DRW_REQ);
  assign busy        = (state != IDLE);
  assign frame_done  = (state == DONE);

endmodule

// File: tb/tb_frame_draw_scheduler.sv
// Randomized directed bench for frame_draw_scheduler: entity words are random,
// expected draw lists come from a slot-order reference model.
module tb_frame_draw_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable1, tick1, clear_done1, draw_done1;
  logic        enable2, tick2, clear_done2, draw_done2;
  logic [2:0]  sel_type1, draw_type1, sel_type2, draw_type2;
  logic [3:0]  sel_index1, sel_index2;
  logic [29:0] ent1, ent2, draw_entity1, draw_entity2;
  logic        clear_start1, draw_start1, busy1, frame_done1, overrun1, timeout_err1;
  logic        clear_start2, draw_start2, busy2, frame_done2, overrun2, timeout_err2;

  logic [29:0] ship_w [1];
  logic [29:0] ast_w  [5];
  logic [29:0] shot_w [10];
  logic [32:0] got1[$], got2[$], exp_q[$];

  int n_assert = 0, n_fail = 0;
  int n_clr = 0, n_fd = 0, n_ov = 0, n_to = 0, n_busy = 0, n_fd2 = 0;
  int cyc = 0, t_ship = 0, t_to = 0;
  int d_cnt = 0, c_cnt = 0;
  bit d_hang = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  frame_draw_scheduler #(.TIMEOUT(64)) dut1 (
    .clk(clk), .reset(reset), .enable(enable1), .frame_tick(tick1),
    .sel_type(sel_type1), .sel_index(sel_index1), .ent_word(ent1),
    .clear_start(clear_start1), .clear_done(clear_done1),
    .draw_start(draw_start1), .draw_entity(draw_entity1), .draw_type(draw_type1),
    .draw_done(draw_done1), .busy(busy1), .frame_done(frame_done1),
    .overrun(overrun1), .timeout_err(timeout_err1));

  frame_draw_scheduler #(.MAX_ASTEROIDS(0)) dut2 (
    .clk(clk), .reset(reset), .enable(enable2), .frame_tick(tick2),
    .sel_type(sel_type2), .sel_index(sel_index2), .ent_word(ent2),
    .clear_start(clear_start2), .clear_done(clear_done2),
    .draw_start(draw_start2), .draw_entity(draw_entity2), .draw_type(draw_type2),
    .draw_done(draw_done2), .busy(busy2), .frame_done(frame_done2),
    .overrun(overrun2), .timeout_err(timeout_err2));

  function automatic logic [29:0] lookup(input logic [2:0] t, input logic [3:0] i);
    logic [29:0] w;
    w = '0;
    case (t)
      3'b100:  if (i == 4'd0) w = ship_w[0];
      3'b010:  if (i < 4'd5)  w = ast_w[i[2:0]];
      3'b001:  if (i < 4'd10) w = shot_w[i];
      default: w = '0;
    endcase
    return w;
  endfunction

  always_comb ent1 = lookup(sel_type1, sel_index1);
  always_comb ent2 = lookup(sel_type2, sel_index2);

  // Reference model: every active slot once, ships then asteroids then shots.
  function automatic void build_exp(input bit with_ast);
    exp_q.delete();
    if (ship_w[0][29]) exp_q.push_back({3'b100, ship_w[0]});
    if (with_ast)
      foreach (ast_w[i]) if (ast_w[i][29]) exp_q.push_back({3'b010, ast_w[i]});
    foreach (shot_w[i]) if (shot_w[i][29]) exp_q.push_back({3'b001, shot_w[i]});
  endfunction

  // mode 0: all active, 1: only asteroid 2 and shot 7, 2: random activity
  task automatic set_words(input int mode);
    logic [29:0] w;
    w = 30'($urandom); w[29] = (mode == 0) ? 1'b1 : (mode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
    ship_w[0] = w;
    for (int i = 0; i < 5; i++) begin
      w = 30'($urandom);
      w[29] = (mode == 0) ? 1'b1 : (mode == 1) ? (i == 2) : 1'($urandom_range(0, 1));
      ast_w[i] = w;
    end
    for (int i = 0; i < 10; i++) begin
      w = 30'($urandom);
      w[29] = (mode == 0) ? 1'b1 : (mode == 1) ? (i == 7) : 1'($urandom_range(0, 1));
      shot_w[i] = w;
    end
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic compare_draws(input string tag, input logic [32:0] got[$]);
    check({tag, "_count"}, got.size(), exp_q.size());
    for (int i = 0; i < got.size() && i < exp_q.size(); i++)
      check($sformatf("%s_draw%0d", tag, i), got[i], exp_q[i]);
  endtask

  task automatic clear_counts();
    n_clr = 0; n_fd = 0; n_ov = 0; n_to = 0; n_busy = 0; n_fd2 = 0;
    got1.delete(); got2.delete();
  endtask

  task automatic pulse_tick1();
    @(posedge clk); #1 tick1 = 1'b1;
    @(posedge clk); #1 tick1 = 1'b0;
  endtask

  task automatic wait_fd(input string tag);
    int guard;
    guard = 0;
    while (n_fd < 1 && guard < 4000) begin @(posedge clk); guard++; end
    #1;
    check({tag, "_frame_done"}, n_fd, 1);
  endtask

  always @(negedge clk) begin
    if (clear_start1) n_clr++;
    if (draw_start1) begin
      got1.push_back({draw_type1, draw_entity1});
      if (draw_type1 == 3'b100) t_ship = cyc;
    end
    if (frame_done1) n_fd++;
    if (overrun1) n_ov++;
    if (timeout_err1) begin n_to++; t_to = cyc; end
    if (busy1) n_busy++;
    if (draw_start2) got2.push_back({draw_type2, draw_entity2});
    if (frame_done2) n_fd2++;
  end

  // Handshake responder for dut1: clear_done 3 cycles, draw_done 2 cycles after start.
  initial begin
    clear_done1 = 1'b0; draw_done1 = 1'b0;
    forever begin
      @(posedge clk); #1;
      draw_done1 = 1'b0; clear_done1 = 1'b0;
      if (d_cnt > 0) begin d_cnt--; if (d_cnt == 0) draw_done1 = 1'b1; end
      if (c_cnt > 0) begin c_cnt--; if (c_cnt == 0) clear_done1 = 1'b1; end
      if (draw_start1 && !d_hang) d_cnt = 2;
      if (clear_start1) c_cnt = 3;
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    int guard;
    reset = 1'b1; enable1 = 1'b1; tick1 = 1'b0;
    enable2 = 1'b1; tick2 = 1'b0; clear_done2 = 1'b1; draw_done2 = 1'b1;
    set_words(0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy1, 0);
    check("rst_sel", {sel_type1, sel_index1}, 0);
    check("rst_starts", {clear_start1, draw_start1, frame_done1, overrun1, timeout_err1}, 0);
    check("rst_draw", {draw_type1, draw_entity1}, 0);
    check("rst_busy2", busy2, 0);
    reset = 1'b0;

    // all slots active
    clear_counts(); set_words(0); build_exp(1);
    pulse_tick1(); wait_fd("all");
    check("all_clear_start", n_clr, 1);
    compare_draws("all", got1);
    check("all_no_timeout", n_to, 0);
    check("all_no_overrun", n_ov, 0);

    // sparse: asteroid 2 and shot 7 only
    clear_counts(); set_words(1); build_exp(1);
    pulse_tick1(); wait_fd("sparse");
    compare_draws("sparse", got1);

    // random activity patterns
    for (int k = 0; k < 3; k++) begin
      clear_counts(); set_words(2); build_exp(1);
      pulse_tick1(); wait_fd($sformatf("rand%0d", k));
      compare_draws($sformatf("rand%0d", k), got1);
    end

    // drawer never answers the ship
    clear_counts(); set_words(0); build_exp(1);
    d_hang = 1'b1;
    pulse_tick1();
    guard = 0;
    while (n_to < 1 && guard < 500) begin @(posedge clk); guard++; end
    #1 d_hang = 1'b0;
    wait_fd("tmo");
    check("tmo_count", n_to, 1);
    check("tmo_latency", t_to - t_ship, 64);
    check("tmo_next_ast0", (got1.size() > 1) ? got1[1] : 33'h0, {3'b010, ast_w[0]});
    compare_draws("tmo", got1);

    // frame_tick mid-frame, with enable dropped as well
    clear_counts(); set_words(2); ship_w[0][29] = 1'b1; build_exp(1);
    pulse_tick1();
    guard = 0;
    while (got1.size() < 1 && guard < 500) begin @(posedge clk); guard++; end
    #1 tick1 = 1'b1; enable1 = 1'b0;
    @(posedge clk); #1 tick1 = 1'b0;
    wait_fd("ovr");
    enable1 = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("ovr_pulses", n_ov, 1);
    check("ovr_one_frame", n_fd, 1);
    check("ovr_one_clear", n_clr, 1);
    compare_draws("ovr", got1);

    // asynchronous reset while waiting on the drawer
    clear_counts(); set_words(0);
    d_hang = 1'b1;
    pulse_tick1();
    guard = 0;
    while (got1.size() < 1 && guard < 500) begin @(posedge clk); guard++; end
    #3;
    check("mid_busy_before", busy1, 1);
    reset = 1'b1;
    #1;
    check("mid_busy", busy1, 0);
    check("mid_outs", {draw_start1, sel_type1, draw_entity1}, 0);
    #2 reset = 1'b0; d_hang = 1'b0;
    clear_counts();
    repeat (30) @(posedge clk);
    #1;
    check("post_rst_idle", {n_busy, n_clr, n_fd}, 0);
    check("post_rst_draws", got1.size(), 0);

    // tick ignored while disabled
    clear_counts(); enable1 = 1'b0;
    pulse_tick1();
    repeat (10) @(posedge clk);
    #1;
    check("dis_busy", n_busy, 0);
    check("dis_clear", n_clr, 0);
    check("dis_overrun", n_ov, 0);
    enable1 = 1'b1;

    // build with no asteroid slots
    clear_counts(); set_words(0); build_exp(0);
    @(posedge clk); #1 tick2 = 1'b1;
    @(posedge clk); #1 tick2 = 1'b0;
    guard = 0;
    while (n_fd2 < 1 && guard < 2000) begin @(posedge clk); guard++; end
    #1;
    check("noast_frame_done", n_fd2, 1);
    compare_draws("noast", got2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
